cache_control_nway: RTL
=======================

// Module: cache_control_nway
// PURPOSE
//  Control FSM for a WAYS-way set-associative write-back, write-allocate cache with tree pseudo-LRU.
//  Sits between the CPU memory port and the cacheline adaptor.
//  Drives the cache datapath: data/tag/valid/dirty/PLRU arrays, data-in mux and address mux.
//  Latches the miss victim so refill is immune to array changes mid-miss.
// PARAMETERS
//  WAYS  4  associativity; power of 2, 2..8
//  WB    $clog2(WAYS)  derived; way index width, not overridable
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, synchronous, active-high
//  mem_read     in   1       CPU read request, held until mem_resp
//  mem_write    in   1       CPU write request, held until mem_resp
//  mem_resp     out  1       CPU request done, 1-cycle pulse
//  valid_i      in   WAYS    valid bits of indexed set
//  dirty_i      in   WAYS    dirty bits of indexed set
//  cmp_i        in   WAYS    tag-compare match per way
//  plru_i       in   WAYS-1  PLRU tree of indexed set
//  way_o        out  WB      way for data-out mux / address mux / data write
//  dimux_sel    out  1       0=CPU wdata256, 1=pmem rdata
//  we_mode      out  2       write enable for way_o: 00 none, 01 CPU mbe, 10 all ones
//  addrmux_sel  out  1       0=CPU address, 1=stored tag of way_o (writeback)
//  plru_load    out  1       write plru_o to indexed set
//  plru_o       out  WAYS-1  updated PLRU tree
//  valid_load   out  WAYS    one-hot valid write; value valid_o
//  valid_o      out  1
//  dirty_load   out  WAYS    one-hot dirty write; value dirty_o
//  dirty_o      out  1
//  tag_load     out  WAYS    one-hot tag write
//  pmem_read    out  1       line fill request, held until pmem_resp
//  pmem_write   out  1       line writeback request, held until pmem_resp
//  pmem_resp    in   1       cacheline adaptor done
// BEHAVIOUR
//  - Defaults: all outputs 0 (way_o = victim_q outside HIT_CHECK).
//  - While rst=1, all outputs forced to defaults. Edge with rst: state<=HIT_CHECK, victim_q<=0.
//  - hit = |(valid_i & cmp_i); hit_way = lowest set index of (valid_i & cmp_i).
//  - PLRU tree, node 0 = root, children of node n = 2n+1 (lower half), 2n+2 (upper half).
//    bit=1 -> LRU in upper half. Victim: walk from root to leaf.
//    Access to way w: every node on w's path is set to point away from w; others keep plru_i.
//  - FSM state HIT_CHECK, req = mem_read|mem_write:
//      req&hit: mem_resp=1, way_o=hit_way, plru_load=1 (touch hit_way). Stay.
//        write: we_mode=01, dimux_sel=0, dirty_load[hit_way]=1, dirty_o=1.
//      req&!hit: victim_q<=victim.
//        -> WRITE_BACK if valid_i[victim]&dirty_i[victim], else READ_BACK. No mem_resp.
//      !req: idle, stay.
//  - WRITE_BACK: pmem_write=1, addrmux_sel=1, way_o=victim_q. On pmem_resp -> READ_BACK.
//  - READ_BACK: pmem_read=1, addrmux_sel=0, way_o=victim_q.
//      On pmem_resp cycle only: dimux_sel=1, we_mode=10, tag_load/valid_load/dirty_load one-hot victim_q,
//      valid_o=1, dirty_o=0. Then -> HIT_CHECK.
//  - Miss latency: serviced by the hit in the first HIT_CHECK cycle after refill.
//    No PLRU update during miss states; the final hit updates PLRU.
//  - victim_q is captured only on the miss-detect edge.
//    plru_i/valid_i/dirty_i changes during WRITE_BACK/READ_BACK are ignored.
//  - Request dropped mid-miss: the fill still completes; FSM returns to HIT_CHECK.
//  - rst mid-miss: pmem_read/pmem_write low from the next cycle. Adaptor is reset with the same rst.
//  - mem_read and mem_write both high: treated as a write.
// CONFIGURATION
//  CACHE_INVALID_FIRST_EN defined: victim = lowest-index way with valid_i=0 if any, else PLRU victim.
//  Undefined: victim = PLRU victim always.
//  In both cases, an invalid victim is never written back.
// TESTING (WAYS=4)
//  1 read, valid=1111 cmp=0100 plru_i=000 -> same-cycle mem_resp=1, way_o=2, plru_load=1, plru_o=100.
//  2 write, valid=1111 cmp=0010 -> mem_resp=1, way_o=1, we_mode=01, dirty_load=0010, dirty_o=1.
//  3 read, cmp=0000 dirty=0000 plru_i=011 -> READ_BACK, pmem_read=1, way_o=2 until resp.
//    Resp cycle: tag_load=valid_load=0100, we_mode=10. Next cycle: mem_resp=1.
//  4 same with dirty=0100, plru_i flips to 000 during WRITE_BACK -> pmem_write=1, addrmux_sel=1, way_o=2.
//    Then READ_BACK with way_o still 2.
//  5 miss, valid=1011 plru_i=000 -> victim way 2 with CACHE_INVALID_FIRST_EN, way 0 without.
//  6 rst raised mid-WRITE_BACK -> next cycle pmem_write=0, state HIT_CHECK, no mem_resp.

Source files
------------

// File: rtl/cache_control_nway.sv
// cache_control_nway: control FSM for an N-way set-associative write-back,
// write-allocate cache with tree pseudo-LRU replacement.
// Hits are answered combinationally in HIT_CHECK. On a miss, the victim way is
// latched and the FSM goes through an optional WRITE_BACK and then READ_BACK.
// Once the refill completes, the access is replayed as a hit.
// Optional feature: define CACHE_INVALID_FIRST_EN to prefer an invalid way as
// the victim over the PLRU choice.
//
// Handshake: mem_read/mem_write are held by the CPU until the 1-cycle mem_resp
// pulse. pmem_read/pmem_write are held by this block until the adaptor pulses
// pmem_resp. A transfer completes on the clock edge where request and response
// are both high.
module cache_control_nway #(
  parameter int WAYS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  output logic                     mem_resp,
  input  logic [WAYS-1:0]          valid_i,
  input  logic [WAYS-1:0]          dirty_i,
  input  logic [WAYS-1:0]          cmp_i,
  input  logic [WAYS-2:0]          plru_i,
  output logic [$clog2(WAYS)-1:0]  way_o,
  output logic                     dimux_sel,
  output logic [1:0]               we_mode,
  output logic                     addrmux_sel,
  output logic                     plru_load,
  output logic [WAYS-2:0]          plru_o,
  output logic [WAYS-1:0]          valid_load,
  output logic                     valid_o,
  output logic [WAYS-1:0]          dirty_load,
  output logic                     dirty_o,
  output logic [WAYS-1:0]          tag_load,
  output logic                     pmem_read,
  output logic                     pmem_write,
  input  logic                     pmem_resp,
  output logic [1:0]               state_o
);

  localparam int WB = $clog2(WAYS);

  typedef enum logic [1:0] {
    HIT_CHECK  = 2'd0,
    WRITE_BACK = 2'd1,
    READ_BACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WB-1:0]   victim_q, victim_d;

  logic            req;
  logic            hit;
  logic [WAYS-1:0] hit_vec;
  logic [WB-1:0]   hit_way;
  logic [WAYS-1:0] hit_oh;
  logic [WAYS-1:0] victim_oh;
  logic [WB-1:0]   victim;

  // Walk the tree from the root; each node bit selects the LRU half.
  function automatic logic [WB-1:0] plru_victim(input logic [WAYS-2:0] t);
    int   node;
    logic b;
    node = 0;
    for (int l = 0; l < WB; l++) begin
      b = 1'b0;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) b = t[n];
      end
      node = b ? (2 * node + 2) : (2 * node + 1);
    end
    return WB'(node - (WAYS - 1));
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                 input logic [WB-1:0]   w);
    logic [WAYS-2:0] r;
    int              node;
    logic            b;
    r    = t;
    node = 0;
    for (int l = 0; l < WB; l++) begin
      b = w[WB-1-l];
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) r[n] = ~b;
      end
      node = b ? (2 * node + 2) : (2 * node + 1);
    end
    return r;
  endfunction

  assign req       = mem_read | mem_write;
  assign hit_vec   = valid_i & cmp_i;
  assign hit       = |hit_vec;
  assign hit_oh    = WAYS'(1) << hit_way;
  assign victim_oh = WAYS'(1) << victim_q;
  assign state_o   = state_q;

  // Lowest-index matching way.
  always_comb begin
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WB'(i);
    end
  end

  // Replacement choice for the current set.
  always_comb begin
    victim = plru_victim(plru_i);
`ifdef CACHE_INVALID_FIRST_EN
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim = WB'(i);
    end
`endif
  end

  // Next state; victim is captured only on the miss-detect edge.
  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      HIT_CHECK: begin
        if (req && !hit) begin
          victim_d = victim;
          state_d  = (valid_i[victim] && dirty_i[victim]) ? WRITE_BACK : READ_BACK;
        end
      end
      WRITE_BACK: if (pmem_resp) state_d = READ_BACK;
      READ_BACK:  if (pmem_resp) state_d = HIT_CHECK;
      default:    state_d = HIT_CHECK;
    endcase
  end

  // State and latched victim registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HIT_CHECK;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  // Datapath and memory-side control decoded from state and set inputs.
  always_comb begin
    mem_resp    = 1'b0;
    way_o       = '0;
    dimux_sel   = 1'b0;
    we_mode     = 2'b00;
    addrmux_sel = 1'b0;
    plru_load   = 1'b0;
    plru_o      = '0;
    valid_load  = '0;
    valid_o     = 1'b0;
    dirty_load  = '0;
    dirty_o     = 1'b0;
    tag_load    = '0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    if (!rst) begin
      case (state_q)
        HIT_CHECK: begin
          if (req && hit) begin
            mem_resp  = 1'b1;
            way_o     = hit_way;
            plru_load = 1'b1;
            plru_o    = plru_touch(plru_i, hit_way);
            if (mem_write) begin
              we_mode    = 2'b01;
              dirty_load = hit_oh;
              dirty_o    = 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          way_o       = victim_q;
          pmem_write  = 1'b1;
          addrmux_sel = 1'b1;
        end
        READ_BACK: begin
          way_o     = victim_q;
          pmem_read = 1'b1;
          if (pmem_resp) begin
            dimux_sel  = 1'b1;
            we_mode    = 2'b10;
            tag_load   = victim_oh;
            valid_load = victim_oh;
            dirty_load = victim_oh;
            valid_o    = 1'b1;
          end
        end
        default: way_o = victim_q;
      endcase
    end
  end

endmodule
